maxpool2x2_stream: RTL

- Downstream neighbour of the conv output feature-map buffer. Drains one FM_SIZE x FM_SIZE map from that buffer in raster order.
- Drives the buffer's read enable, which has 1-cycle read latency and returns 0 when not reading. Performs 2x2 stride-2 max pooling on the fly and emits the pooled map in raster order to the next layer.
- One frame per start pulse.

---
 rtl/conv_pkg.sv | 36 +++
 rtl/pool_line_buf.sv | 36 +++
 rtl/maxpool2x2_stream.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared conv-pipeline definitions: conv output size helper, sample type,
// and the pooling stage FSM encoding.
package conv_pkg;

  // Default sample width of the conv pipeline.
  localparam int DATA_W = 16;

  // Conv layer geometry feeding the pooling stage.
  localparam int IFM_SIZE    = 7;
  localparam int KERNEL_SIZE = 3;
  localparam int CONV_STRIDE = 1;
  localparam int CONV_PAD    = 0;

  // Signed two's complement sample at the default pipeline width.
  typedef logic signed [DATA_W-1:0] data_t;

  // Pooling stage frame sequencing.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Side length of the conv output map for a given input side, kernel,
  // stride and padding.
  function automatic int conv_out_size(input int ifm, input int k,
                                       input int s, input int p);
    return (ifm - k + 2 * p) / s + 1;
  endfunction

  // Side length of the map the pooling stage drains.
  localparam int CONV_DEPTH = conv_out_size(IFM_SIZE, KERNEL_SIZE,
                                            CONV_STRIDE, CONV_PAD);

endpackage

// File: rtl/pool_line_buf.sv
// Holds one horizontally-pooled value per output column while the next
// input row is streamed in. One write port, one combinational read port.
module pool_line_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2,
  parameter int AW         = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  // Next contents: update the addressed entry on a write, hold otherwise.
  always_comb begin
    mem_d = mem_q;
    if (we && (int'(waddr) < DEPTH)) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage registers; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max pooling. Drains an FM_SIZE x FM_SIZE map from
// a 1-cycle-latency buffer in raster order and emits the pooled map in
// raster order. Odd last row/column is read and discarded.
// Build option: define MAXPOOL_RELU_EN to clamp negative pooled results
// to zero (fused ReLU); timing is unchanged.
module maxpool2x2_stream
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int FM_SIZE    = CONV_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  rd_req,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int POOL_SIZE = FM_SIZE / 2;
  localparam int CW        = $clog2(FM_SIZE);
  localparam int NW        = $clog2(FM_SIZE * FM_SIZE);
  localparam int AW        = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(FM_SIZE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(FM_SIZE * FM_SIZE - 1);
  localparam bit FM_ODD = ((FM_SIZE % 2) == 1);

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  // Signed maximum at full width.
  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

  // Post-processing applied to each pooled result before it is registered.
  function automatic sample_t pool_post(input sample_t v);
`ifdef MAXPOOL_RELU_EN
    return v[DATA_WIDTH-1] ? sample_t'('0) : v;
`else
    return v;
`endif
  endfunction

  state_e        state_q, state_d;
  logic          rd_req_q, rd_req_d;
  logic [NW-1:0] rd_cnt_q, rd_cnt_d;
  logic          vld_q, vld_d;
  logic [CW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  sample_t       pair_q, pair_d;
  sample_t       d_out_q, d_out_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;

  sample_t                d_in_s;
  logic                   last_beat_s;
  logic                   in_win_s;
  logic                   lb_we_s;
  logic [AW-1:0]          lb_addr_s;
  logic [DATA_WIDTH-1:0]  lb_wdata_s;
  logic [DATA_WIDTH-1:0]  lb_rdata_s;

  assign d_in_s      = sample_t'(d_in);
  assign last_beat_s = vld_q && (r_q == C_LAST) && (c_q == C_LAST);
  assign in_win_s    = !(FM_ODD && ((r_q == C_LAST) || (c_q == C_LAST)));
  assign lb_addr_s   = AW'(c_q >> 1);

  // Frame sequencing: issue exactly FM_SIZE^2 reads, then wait for the last beat.
  always_comb begin
    state_d      = state_q;
    rd_req_d     = rd_req_q;
    rd_cnt_d     = rd_cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_READ;
          rd_req_d = 1'b1;
          rd_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rd_cnt_q == N_LAST) begin
          state_d  = ST_DRAIN;
          rd_req_d = 1'b0;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (last_beat_s) begin
          state_d      = ST_DONE;
          frame_done_d = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        rd_req_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Beat tracking: data follows each read by one cycle; row/col advance per beat.
  always_comb begin
    vld_d = rd_req_q;
    r_d   = r_q;
    c_d   = c_q;
    if (vld_q) begin
      if (c_q == C_LAST) begin
        c_d = '0;
        r_d = (r_q == C_LAST) ? '0 : (r_q + 1'b1);
      end else begin
        c_d = c_q + 1'b1;
      end
    end else begin
      c_d = c_q;
    end
  end

  // Pooling datapath: horizontal pair on even rows is stashed per column pair,
  // then combined with the odd row to finish each 2x2 window.
  always_comb begin
    pair_d      = pair_q;
    lb_we_s     = 1'b0;
    lb_wdata_s  = smax(pair_q, d_in_s);
    out_valid_d = 1'b0;
    d_out_d     = d_out_q;
    if (vld_q && in_win_s) begin
      case ({r_q[0], c_q[0]})
        2'b00: pair_d = d_in_s;
        2'b01: lb_we_s = 1'b1;
        2'b10: pair_d = smax(sample_t'(lb_rdata_s), d_in_s);
        2'b11: begin
          out_valid_d = 1'b1;
          d_out_d     = pool_post(smax(pair_q, d_in_s));
        end
        default: pair_d = pair_q;
      endcase
    end else begin
      pair_d = pair_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rd_req_q     <= 1'b0;
      rd_cnt_q     <= '0;
      vld_q        <= 1'b0;
      r_q          <= '0;
      c_q          <= '0;
      pair_q       <= '0;
      d_out_q      <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_req_q     <= rd_req_d;
      rd_cnt_q     <= rd_cnt_d;
      vld_q        <= vld_d;
      r_q          <= r_d;
      c_q          <= c_d;
      pair_q       <= pair_d;
      d_out_q      <= d_out_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  pool_line_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (POOL_SIZE),
    .AW        (AW)
  ) u_line_buf (
    .clk  (clk),
    .we   (lb_we_s),
    .waddr(lb_addr_s),
    .wdata(lb_wdata_s),
    .raddr(lb_addr_s),
    .rdata(lb_rdata_s)
  );

  assign rd_req     = rd_req_q;
  assign d_out      = d_out_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
